rom_stream_reader: RTL and testbench

Sequencer that sits directly upstream of the synchronous ROM block. It generates addresses and read enables for a contiguous burst, absorbs the ROM's 1-cycle registered read latency, and presents the words as a valid/ready stream. A 2-entry output buffer gives full throughput (1 word/cycle) with no word loss under backpressure. Typical consumers are display/UART/DAC stages that stream tables or images out of ROM.

---
 rtl/rom_stream_reader.sv | 190 +++++++++++++++++++
 tb/tb_rom_stream_reader.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_stream_reader.sv
// rom_stream_reader: burst address sequencer and 2-deep stream buffer for a 1-cycle ROM.
// Define ROM_STREAM_READER_CHECKSUM_EN to add a running sum of transferred words.
module rom_stream_reader #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int LENGTH_WIDTH  = 17
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Start_i,
  input  logic [ADDRESS_WIDTH-1:0] StartAddress_i,
  input  logic [LENGTH_WIDTH-1:0]  Length_i,
  output logic                     Busy_o,
  output logic                     Done_o,
  output logic                     RomReadEnable_o,
  output logic [ADDRESS_WIDTH-1:0] RomAddress_o,
  input  logic [DATA_WIDTH-1:0]    RomData_i,
  output logic [DATA_WIDTH-1:0]    Data_o,
  output logic                     Valid_o,
  input  logic                     Ready_i
`ifdef ROM_STREAM_READER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]    Checksum_o
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [LENGTH_WIDTH-1:0]  remaining_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic                     inflight_q;
  logic [1:0]               count_q;
  logic [DATA_WIDTH-1:0]    slot0_q;
  logic [DATA_WIDTH-1:0]    slot1_q;

  logic       start_ok;
  logic       pop;
  logic       push;
  logic       issue;
  logic       last_pop;
  logic [1:0] occ;

  assign start_ok = (state_q == IDLE) && Start_i;
  assign pop      = (count_q != 2'd0) && Ready_i;
  assign push     = inflight_q;
  assign occ      = count_q + {1'b0, inflight_q};

  // A read may only be issued if its word is sure to find a free slot.
  assign issue = (state_q == RUN)
              && (remaining_q != '0)
              && ((occ < 2'd2) || ((occ == 2'd2) && pop));

  assign last_pop = pop
                 && (count_q == 2'd1)
                 && !inflight_q
                 && (remaining_q == '0);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (Start_i) begin
          if (Length_i != '0) begin
            state_d = RUN;
          end else begin
            state_d = FINISH;
          end
        end
      end
      RUN: begin
        if (last_pop) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    Busy_o          = 1'b0;
    Done_o          = 1'b0;
    RomReadEnable_o = issue;
    unique case (1'b1)
      (state_q == RUN): begin
        Busy_o = 1'b1;
      end
      (state_q == FINISH): begin
        Busy_o = 1'b1;
        Done_o = 1'b1;
      end
      default: begin
        Busy_o = 1'b0;
      end
    endcase
  end

  assign RomAddress_o = addr_q;
  assign Valid_o      = (count_q != 2'd0);
  assign Data_o       = slot0_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      addr_q      <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      if (start_ok) begin
        addr_q      <= StartAddress_i;
        remaining_q <= Length_i;
      end else if (issue) begin
        addr_q      <= addr_q + ADDRESS_WIDTH'(1);
        remaining_q <= remaining_q - LENGTH_WIDTH'(1);
      end
      inflight_q <= issue;
    end
  end

  // Slot0 is always the head; an emptying pop leaves it untouched.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      count_q <= 2'd0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
      unique case (count_q)
        2'd0: begin
          if (push) begin
            slot0_q <= RomData_i;
          end
        end
        2'd1: begin
          if (push && pop) begin
            slot0_q <= RomData_i;
          end else if (push) begin
            slot1_q <= RomData_i;
          end
        end
        2'd2: begin
          if (pop) begin
            slot0_q <= slot1_q;
            if (push) begin
              slot1_q <= RomData_i;
            end
          end
        end
        default: begin
          slot0_q <= slot0_q;
        end
      endcase
    end
  end

`ifdef ROM_STREAM_READER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      csum_q <= '0;
    end else if (start_ok) begin
      csum_q <= '0;
    end else if (pop) begin
      csum_q <= csum_q + Data_o;
    end
  end

  assign Checksum_o = csum_q;
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader: randomized bursts against a ROM model and word-list reference.
// Set ROM_STREAM_READER_CHECKSUM_EN to also check the checksum output.
module tb_rom_stream_reader;

  logic        Clock;
  logic        Reset;
  logic        Start_i;
  logic [15:0] StartAddress_i;
  logic [16:0] Length_i;
  logic        Busy_o;
  logic        Done_o;
  logic        RomReadEnable_o;
  logic [15:0] RomAddress_o;
  logic [7:0]  RomData_i;
  logic [7:0]  Data_o;
  logic        Valid_o;
  logic        Ready_i;
  logic [7:0]  cks_now;
`ifdef ROM_STREAM_READER_CHECKSUM_EN
  logic [7:0]  Checksum_o;
  assign cks_now = Checksum_o;
`else
  assign cks_now = 8'h00;
`endif

  int total = 0;
  int bad   = 0;

  rom_stream_reader dut (
    .Clock(Clock),
    .Reset(Reset),
    .Start_i(Start_i),
    .StartAddress_i(StartAddress_i),
    .Length_i(Length_i),
    .Busy_o(Busy_o),
    .Done_o(Done_o),
    .RomReadEnable_o(RomReadEnable_o),
    .RomAddress_o(RomAddress_o),
    .RomData_i(RomData_i),
    .Data_o(Data_o),
    .Valid_o(Valid_o),
`ifdef ROM_STREAM_READER_CHECKSUM_EN
    .Checksum_o(Checksum_o),
`endif
    .Ready_i(Ready_i)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [7:0] rom_word(input logic [15:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  always @(posedge Clock) begin
    if (RomReadEnable_o) RomData_i <= rom_word(RomAddress_o);
  end

  function automatic logic ready_val(input int mode, input int cyc);
    logic [5:0] pat;
    pat = 6'b101001;
    case (mode)
      1: return pat[cyc % 6];
      2: return ($urandom % 4) != 0;
      3: return ($urandom % 2) != 0;
      default: return 1'b1;
    endcase
  endfunction

  logic [7:0]  exp_q[$];
  logic [7:0]  got[$];
  logic [15:0] addrs[$];
  int first_valid, first_xfer, last_xfer;
  int done_cnt, done_cyc, occ_bad, timeout;
  logic ena_first;
  logic [7:0] cks_got;

  function automatic logic [7:0] build_exp(input logic [15:0] sa, input int len);
    logic [7:0] s;
    s = 8'h00;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(rom_word(sa + 16'(i)));
      s = s + rom_word(sa + 16'(i));
    end
    return s;
  endfunction

  // Drives one burst and records what the stream did; judging is left to callers.
  task automatic run_burst(input logic [15:0] sa, input int len,
                           input int mode, input bit junk);
    int cyc, issued, xfers, limit;
    got.delete(); addrs.delete();
    first_valid = -1; first_xfer = -1; last_xfer = -1;
    done_cnt = 0; done_cyc = -1; occ_bad = 0; timeout = 0;
    ena_first = 1'b0; cks_got = 8'h00;
    limit = 8 * len + 40;
    @(negedge Clock);
    Start_i = 1'b1; StartAddress_i = sa; Length_i = 17'(len);
    Ready_i = ready_val(mode, 0);
    @(posedge Clock);
    cyc = 0; issued = 0; xfers = 0;
    forever begin
      @(negedge Clock);
      cyc++;
      Start_i = junk && Busy_o && !Done_o && ($urandom % 2 == 0);
      StartAddress_i = 16'($urandom);
      Length_i = 17'($urandom % 9);
      Ready_i = ready_val(mode, cyc);
      #1;
      if (cyc == 1) ena_first = RomReadEnable_o;
      if (RomReadEnable_o) begin
        addrs.push_back(RomAddress_o);
        if ((issued - xfers) >= 2 && !(Valid_o && Ready_i)) occ_bad++;
        issued++;
      end
      if (Valid_o && first_valid < 0) first_valid = cyc;
      if (Valid_o && Ready_i) begin
        got.push_back(Data_o);
        if (first_xfer < 0) first_xfer = cyc;
        last_xfer = cyc;
        xfers++;
      end
      if (Done_o) begin
        done_cnt++;
        done_cyc = cyc;
        cks_got = cks_now;
      end
      if (!Busy_o) break;
      if (cyc > limit) begin
        timeout = 1;
        break;
      end
    end
    Start_i = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b0; Start_i = 1'b0; StartAddress_i = '0;
    Length_i = '0; Ready_i = 1'b0;
    #3;
    total++;
    if ({Busy_o, Done_o, Valid_o, RomReadEnable_o} !== 4'b0) begin
      bad++;
      $display("FAIL reset_ctl got=%b want=0000",
               {Busy_o, Done_o, Valid_o, RomReadEnable_o});
    end
    total++;
    if ({Data_o, RomAddress_o} !== 24'h0) begin
      bad++;
      $display("FAIL reset_data got=%h want=000000", {Data_o, RomAddress_o});
    end
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
  endtask

  task automatic test_basic;
    logic [7:0] s;
    s = build_exp(16'h0010, 4);
    run_burst(16'h0010, 4, 0, 1'b0);
    total++;
    if (timeout != 0) begin bad++; $display("FAIL basic_timeout got=1 want=0"); end
    total++;
    if (got.size() != 4) begin
      bad++; $display("FAIL basic_count got=%0d want=4", got.size());
    end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      total++;
      if (got[i] !== exp_q[i]) begin
        bad++; $display("FAIL basic_word%0d got=%h want=%h", i, got[i], exp_q[i]);
      end
    end
    total++;
    if (ena_first !== 1'b1) begin
      bad++; $display("FAIL basic_first_read got=%b want=1", ena_first);
    end
    total++;
    if (first_valid != 3) begin
      bad++; $display("FAIL basic_first_valid got=%0d want=3", first_valid);
    end
    total++;
    if (last_xfer - first_xfer != 3) begin
      bad++; $display("FAIL basic_throughput got=%0d want=3", last_xfer - first_xfer);
    end
    total++;
    if (done_cnt != 1 || done_cyc != last_xfer + 1) begin
      bad++; $display("FAIL basic_done got=%0d@%0d want=1@%0d",
                      done_cnt, done_cyc, last_xfer + 1);
    end
    total++;
    if (Busy_o !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b want=0", Busy_o); end
`ifdef ROM_STREAM_READER_CHECKSUM_EN
    total++;
    if (cks_got !== 8'h46 || cks_got !== s) begin
      bad++; $display("FAIL basic_checksum got=%h want=%h", cks_got, s);
    end
`endif
  endtask

  task automatic test_backpressure;
    void'(build_exp(16'h0010, 4));
    run_burst(16'h0010, 4, 1, 1'b0);
    total++;
    if (timeout != 0 || got.size() != 4) begin
      bad++; $display("FAIL bp_count got=%0d want=4 timeout=%0d", got.size(), timeout);
    end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      total++;
      if (got[i] !== exp_q[i]) begin
        bad++; $display("FAIL bp_word%0d got=%h want=%h", i, got[i], exp_q[i]);
      end
    end
    total++;
    if (occ_bad != 0) begin bad++; $display("FAIL bp_overissue got=%0d want=0", occ_bad); end
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL bp_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_wrap;
    logic [15:0] want[4];
    want = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    void'(build_exp(16'hFFFE, 4));
    run_burst(16'hFFFE, 4, 3, 1'b0);
    total++;
    if (addrs.size() != 4) begin
      bad++; $display("FAIL wrap_reads got=%0d want=4", addrs.size());
    end
    for (int i = 0; i < addrs.size() && i < 4; i++) begin
      total++;
      if (addrs[i] !== want[i]) begin
        bad++; $display("FAIL wrap_addr%0d got=%h want=%h", i, addrs[i], want[i]);
      end
    end
    total++;
    if (got !== exp_q) begin bad++; $display("FAIL wrap_words got=%p want=%p", got, exp_q); end
  endtask

  task automatic test_zero_length;
    run_burst(16'h1234, 0, 0, 1'b0);
    total++;
    if (done_cnt != 1 || done_cyc != 1) begin
      bad++; $display("FAIL zero_done got=%0d@%0d want=1@1", done_cnt, done_cyc);
    end
    total++;
    if (addrs.size() != 0 || first_valid >= 0) begin
      bad++; $display("FAIL zero_activity got=%0d,%0d want=0,-1", addrs.size(), first_valid);
    end
  endtask

  task automatic test_reset_mid_burst;
    int n;
    n = 0;
    @(negedge Clock);
    Start_i = 1'b1; StartAddress_i = 16'h0040; Length_i = 17'd8; Ready_i = 1'b1;
    for (int c = 0; c < 30 && n < 2; c++) begin
      @(negedge Clock);
      Start_i = 1'b0;
      #1;
      if (Valid_o && Ready_i) n++;
    end
    total++;
    if (n != 2) begin bad++; $display("FAIL rst_mid_reach got=%0d want=2", n); end
    @(posedge Clock);
    #2 Reset = 1'b0;
    #1;
    total++;
    if ({Busy_o, Done_o, Valid_o, RomReadEnable_o, Data_o, RomAddress_o} !== 28'h0) begin
      bad++; $display("FAIL rst_mid_outputs got=%h want=0",
                      {Busy_o, Done_o, Valid_o, RomReadEnable_o, Data_o, RomAddress_o});
    end
    repeat (3) begin
      @(negedge Clock);
      total++;
      if (Done_o !== 1'b0) begin bad++; $display("FAIL rst_mid_done got=%b want=0", Done_o); end
    end
    Reset = 1'b1;
    void'(build_exp(16'h0020, 5));
    run_burst(16'h0020, 5, 3, 1'b0);
    total++;
    if (got !== exp_q || done_cnt != 1) begin
      bad++; $display("FAIL rst_mid_restart got=%p want=%p", got, exp_q);
    end
  endtask

  task automatic test_random;
    logic [15:0] sa;
    logic [7:0]  s;
    int len;
    for (int k = 0; k < 8; k++) begin
      sa  = 16'($urandom);
      len = int'($urandom_range(0, 24));
      s   = build_exp(sa, len);
      run_burst(sa, len, 2 + (k % 2), 1'b1);
      total++;
      if (timeout != 0 || got !== exp_q) begin
        bad++; $display("FAIL rand%0d_words sa=%h len=%0d got=%p want=%p",
                        k, sa, len, got, exp_q);
      end
      total++;
      if (done_cnt != 1 || occ_bad != 0 || addrs.size() != len) begin
        bad++; $display("FAIL rand%0d_ctl got=%0d,%0d,%0d want=1,0,%0d",
                        k, done_cnt, occ_bad, addrs.size(), len);
      end
`ifdef ROM_STREAM_READER_CHECKSUM_EN
      total++;
      if (cks_got !== s) begin
        bad++; $display("FAIL rand%0d_checksum got=%h want=%h", k, cks_got, s);
      end
`endif
    end
  endtask

  initial begin
    RomData_i = 8'h00;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_length();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
